sevenseg_capture: RTL
=====================

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive synchronized cycles that anode and segment inputs must hold before capture (legal range 2..255).
REQ-002 SHALL have port clock, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have ports a, b, c, d, e, f, g, each input, 1: scanned segment lines, active-low.
REQ-005 SHALL have port dp, input, 1: scanned decimal-point line, active-low.
REQ-006 SHALL have port an, input, 4: scanned anode enables, active-low, an[0] selects digit 0.
REQ-007 SHALL have ports out0, out1, out2, out3, each output, 4: recovered hex value per digit.
REQ-008 SHALL have port dp_out, output, 4: recovered decimal point per digit, active-high.
REQ-009 SHALL have port digit_valid, output, 4: sticky flag per digit, set on first good capture.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when all four digits have been captured since the last pulse.
REQ-011 SHALL have port pat_err, output, 1: one-cycle pulse on a stable but undecodable segment pattern.

Function
REQ-012 SHALL pass a..g, dp, an through a two-flop synchronizer before any other use.
REQ-013 SHALL implement FSM states WAIT_AN, SETTLE, HELD.
REQ-014 WAIT_AN: synchronized an not exactly one-hot (none or several low) -> stay; one-hot -> SETTLE with stable counter = 1.
REQ-015 SETTLE: each cycle synced {an, segments, dp} equal previous cycle -> counter +1; any change -> counter reloads to 1 (or WAIT_AN if an no longer one-hot).
REQ-016 SETTLE: counter reaching STABLE_CYCLES -> capture performed in that cycle, go to HELD; counter saturates, never wraps.
REQ-017 HELD: no further capture until synced an changes; then one-hot -> SETTLE (counter = 1), else WAIT_AN.
REQ-018 Capture of a hex glyph SHALL load outN and dp_out[N] for the active anode N at that edge; other digits unchanged.
REQ-019 Capture SHALL set digit_valid[N] and internal seen[N]; digit_valid stays set until reset.
REQ-020 Latency: output update SHALL occur STABLE_CYCLES+2 clock edges after inputs settle to a new one-hot value.
REQ-021 Decoding SHALL accept exactly the 16 glyphs 0-9, A, b, C, d, E, F of the shared glyph table; dp ignored by decoding.
REQ-022 Undecodable stable pattern (including blank) SHALL pulse pat_err for one cycle at the capture edge, leave outN/dp_out[N]/digit_valid/seen unchanged, and enter HELD.
REQ-023 When a capture makes seen == 4'b1111, frame_done SHALL pulse on the next cycle and seen SHALL clear in the same cycle; a capture in that same cycle SHALL set its seen bit after the clear.
REQ-024 Repeat captures of a digit already in seen SHALL update outN but not trigger frame_done.

Reset
REQ-025 reset high SHALL immediately clear synchronizers, counter, seen, out0..out3 = 0, dp_out = 0, digit_valid = 0, frame_done = 0, pat_err = 0, FSM = WAIT_AN.
REQ-026 Reset asserted mid-SETTLE or mid-frame SHALL discard partial capture; after release, first capture SHALL need a full STABLE_CYCLES window.

Structure
REQ-027 Shared package SHALL hold the 16-entry active-low glyph table (a..g order), FSM state typedef, and anode one-hot constants.
REQ-028 Glyph-to-nibble decoding SHALL be a combinational sub-module seg_decode (7-bit pattern in, 4-bit value and valid out).

Verification
REQ-029 an=1110, a..g=0000001, dp=1 held 10 cycles -> out0=0, dp_out[0]=0, digit_valid=0001 at cycle 6 after settle.
REQ-030 Scan digits 0..3 with glyphs 1, 2, 3, F (F = 0111000) at 16 cycles each -> out0..3 = 1,2,3,F; single frame_done pulse after digit 3 capture.
REQ-031 an=1011, pattern 1111111 (blank) held 10 cycles -> one pat_err pulse, out2 and digit_valid[2] unchanged.
REQ-032 an toggling every 3 cycles (< STABLE_CYCLES) -> no capture, no pat_err; an=1100 held -> stays WAIT_AN, no capture.
REQ-033 Reset pulse during second frame -> all outputs 0 instantly; subsequent full scan -> frame_done only after all four digits recaptured.

Source files
------------

// File: rtl/sevenseg_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block: glyph table,
// FSM state type and active-low anode one-hot codes.
package sevenseg_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_AN,
        SETTLE,
        HELD
    } state_t;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    // Active-low patterns ordered {a,b,c,d,e,f,g}; index is the hex value.
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic an_onehot(input logic [3:0] an);
        return (an == AN_DIG0) || (an == AN_DIG1) || (an == AN_DIG2) || (an == AN_DIG3);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            AN_DIG1: return 2'd1;
            AN_DIG2: return 2'd2;
            AN_DIG3: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_capture_seg_decode.sv
// Combinational glyph-to-nibble decoder; valid is low for any pattern
// outside the 16-entry table.
module seg_decode
    import sevenseg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers per-digit hex values from a scanned, active-low seven-segment
// display bus once anode and segments have been stable long enough.
module sevenseg_capture
    import sevenseg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    input  logic [3:0] an,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] dp_out,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       pat_err
);

    logic [11:0] raw, sync1, sync2, prev;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic        dp_s;
    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic        capture, same;
    logic [3:0]  seen, seen_d;
    logic [3:0]  dec_val;
    logic        dec_ok;
    logic [1:0]  idx;

    assign raw   = {an, a, b, c, d, e, f, g, dp};
    assign an_s  = sync2[11:8];
    assign seg_s = sync2[7:1];
    assign dp_s  = sync2[0];
    assign same  = (sync2 == prev);
    assign idx   = an_index(an_s);

    seg_decode u_seg_decode (
        .pattern (seg_s),
        .value   (dec_val),
        .valid   (dec_ok)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        case (state)
            WAIT_AN: begin
                if (an_onehot(an_s)) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (!same) begin
                    cnt_d = 8'd1;
                    if (!an_onehot(an_s)) state_d = WAIT_AN;
                end else begin
                    if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
                    // cnt is this cycle's count minus one, so capture lands on the edge where it reaches STABLE_CYCLES
                    if (cnt >= 8'(STABLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            HELD: begin
                if (an_s != prev[11:8]) begin
                    cnt_d   = 8'd1;
                    state_d = an_onehot(an_s) ? SETTLE : WAIT_AN;
                end
            end
            default: state_d = WAIT_AN;
        endcase
    end

    // A completed frame clears seen before this cycle's capture adds its bit.
    always_comb begin
        seen_d = (seen == 4'b1111) ? 4'b0000 : seen;
        if (capture && dec_ok) seen_d[idx] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            state       <= WAIT_AN;
            cnt         <= '0;
            seen        <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            pat_err     <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            prev       <= sync2;
            state      <= state_d;
            cnt        <= cnt_d;
            seen       <= seen_d;
            frame_done <= (seen == 4'b1111);
            pat_err    <= capture && !dec_ok;
            if (capture && dec_ok) begin
                case (idx)
                    2'd0:    out0 <= dec_val;
                    2'd1:    out1 <= dec_val;
                    2'd2:    out2 <= dec_val;
                    default: out3 <= dec_val;
                endcase
                dp_out[idx]      <= ~dp_s;
                digit_valid[idx] <= 1'b1;
            end
        end
    end

endmodule
